ram_arbiter: RTL

//  Shares the single-port iobus RAM between the CPU instruction-fetch port (I)
//  and the load/store data port (D). Single-cycle RAM read latency.

---
 rtl/ktc32_bus_pkg.sv | 10 +
 rtl/ram_arb_pick.sv | 25 ++
 rtl/ram_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ktc32_bus_pkg.sv
// Shared types for the iobus RAM arbiter: FSM states, port ownership and word geometry.
package ktc32_bus_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for a new grant out of IDLE. Define RAM_ARB_RR_EN for round-robin
// between contending ports; otherwise D has fixed priority over I.
module ram_arb_pick
  import ktc32_bus_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef RAM_ARB_RR_EN
  input  owner_t rr_last,
`endif
  output logic   any_req,
  output owner_t winner
);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    any_req = i_req | d_req;
    winner  = d_req ? OWN_D : OWN_I;
`ifdef RAM_ARB_RR_EN
    if (i_req && d_req)
      winner = (rr_last == OWN_D) ? OWN_I : OWN_D;
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port iobus RAM between instruction fetch (I) and load/store (D).
// Each access runs IDLE -> ISSUE -> RESP; RAM_ARB_RR_EN selects round-robin contention.
module ram_arbiter
  import ktc32_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-3:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  arb_state_t state;
  owner_t     owner;
  owner_t     winner;
  owner_t     grant_owner;
  logic       any_req;
  logic       grant_go;
  logic       unused_addr_lsbs;

`ifdef RAM_ARB_RR_EN
  owner_t rr_last;
`endif

  // Byte-offset bits are meaningless for a word-addressed RAM.
  assign unused_addr_lsbs = ^{i_addr[WORD_SHIFT-1:0], d_addr[WORD_SHIFT-1:0]};

  ram_arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
`ifdef RAM_ARB_RR_EN
    .rr_last (rr_last),
`endif
    .any_req (any_req),
    .winner  (winner)
  );

  // A new grant starts from IDLE (arbitrated) or from RESP (hand-off to the other port only).
  always_comb begin
    grant_go    = 1'b0;
    grant_owner = winner;
    case (state)
      IDLE: grant_go = any_req;
      RESP: begin
        grant_owner = (owner == OWN_I) ? OWN_D : OWN_I;
        grant_go    = (owner == OWN_I) ? d_req : i_req;
      end
      default: grant_go = 1'b0;
    endcase
  end

  // Read data flows straight from the RAM; it is only meaningful alongside the ack.
  assign i_rdata = ram_rdata;
  assign d_rdata = ram_rdata;

  // NOTE: state is updated with non-blocking assignments only, and reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_I;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
`ifdef RAM_ARB_RR_EN
      rr_last   <= OWN_D;
`endif
    end else begin
      case (state)
        IDLE, RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          if (grant_go) begin
            state  <= ISSUE;
            owner  <= grant_owner;
            ram_en <= 1'b1;
`ifdef RAM_ARB_RR_EN
            rr_last <= grant_owner;
`endif
            if (grant_owner == OWN_D) begin
              ram_addr  <= d_addr[ADDR_W-1:WORD_SHIFT];
              ram_we    <= d_we ? d_be : '0;
              ram_wdata <= d_wdata;
            end else begin
              ram_addr  <= i_addr[ADDR_W-1:WORD_SHIFT];
              ram_we    <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state  <= RESP;
          ram_en <= 1'b0;
          ram_we <= '0;
          i_ack  <= (owner == OWN_I);
          d_ack  <= (owner == OWN_D);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && state == ISSUE)
      assert (owner == OWN_I ? i_req : d_req)
        else $error("ram_arbiter: request dropped before ack");
  end
`endif

endmodule
